// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the RAM-port sequencer/arbiter.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        LOAD,
        STORE,
        DONE
    } ctrlStateT;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // Size code 3 is treated as a word access.
    function automatic logic [2:0] sizeToBytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: sizeToBytes = 3'd1;
            SIZE_HALF: sizeToBytes = 3'd2;
            SIZE_WORD: sizeToBytes = 3'd4;
            default:   sizeToBytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_byte_sequencer.sv
// Byte counter, RAM address generator and little-endian shift assembler,
// shared by every transfer type of mem_controller.
module ram_byte_sequencer #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = $clog2(MAX_LEN) + 1
) (
    input  logic                 clkIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 start,
    input  logic                 step,
    input  logic                 capture,
    input  logic                 clear,
    input  logic [31:0]          base,
    input  logic [CNT_W-1:0]     length,
    input  logic [7:0]           dataIn,
    output logic [31:0]          addr,
    output logic [CNT_W-1:0]     count,
    output logic [MAX_LEN*8-1:0] assembledNext
);

    logic [MAX_LEN*8-1:0] assembled;
    logic [CNT_W-1:0]     nextCount;

    assign nextCount = count + 1'b1;

    // New bytes enter at the top, so byte 0 ends up lowest after a full line;
    // shorter transfers leave their bytes in the top lanes.
    assign assembledNext = {dataIn, assembled[MAX_LEN*8-1:8]};

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            addr      <= '0;
            count     <= '0;
            assembled <= '0;
        end else if (readyIn) begin
            if (start) begin
                addr      <= base;
                count     <= '0;
                assembled <= '0;
            end else begin
                if (capture) begin
                    assembled <= assembledNext;
                end
                if (clear) begin
                    addr  <= '0;
                    count <= '0;
                end else if (step) begin
                    count <= nextCount;
                    // Address drops to zero once the last byte has been issued.
                    addr  <= (nextCount == length) ? '0 : addr + 32'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_controller.sv
// Arbiter and byte-wide sequencer for the single RAM port shared by the
// instruction-cache refill path and the load/store unit.
module mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH = 4,
    parameter int unsigned BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                    clkIn,
    input  logic                    resetIn,
    input  logic                    readyIn,
    input  logic                    flushIn,
    input  logic                    icacheMiss,
    input  logic [31:BLOCK_WIDTH]   icacheMissAddr,
    output logic                    icacheFillValid,
    output logic [31:BLOCK_WIDTH]   icacheFillAddr,
    output logic [BLOCK_SIZE*8-1:0] icacheFillData,
    input  logic                    lsuValid,
    input  logic                    lsuWrite,
    input  logic [1:0]              lsuSize,
    input  logic [31:0]             lsuAddr,
    input  logic [31:0]             lsuWriteData,
    output logic                    lsuDone,
    output logic [31:0]             lsuReadData,
    input  logic [7:0]              memIn,
    output logic [7:0]              memOut,
    output logic [31:0]             memAddr,
    output logic                    memWrite,
    input  logic                    ioBufferFull
);

    localparam int unsigned CNT_W     = BLOCK_WIDTH + 1;
    localparam int unsigned LINE_BITS = BLOCK_SIZE * 8;

    ctrlStateT state, nextState;

    logic                   seqStart, seqStep, seqCapture, seqClear;
    logic                   acceptLsu, acceptFetch, finishRead, finishStore;
    logic                   ioStall;
    logic [CNT_W-1:0]       seqCount, seqLength, lsuLen;
    logic [31:0]            seqBase, seqAddr, storeShift, loadWord;
    logic [LINE_BITS-1:0]   seqAssembledNext;
    logic [31:BLOCK_WIDTH]  lineAddrQ;
    logic                   memWriteQ;

    assign memAddr   = seqAddr;
    assign seqBase   = lsuValid ? lsuAddr : {icacheMissAddr, {BLOCK_WIDTH{1'b0}}};
    assign seqLength = (state == IFETCH) ? CNT_W'(BLOCK_SIZE) : lsuLen;
    assign ioStall   = (state == STORE) && (seqAddr[17:16] == IO_ADDR_HI) && ioBufferFull;
    assign memWrite  = memWriteQ && readyIn && !ioStall;

    ram_byte_sequencer #(
        .MAX_LEN(BLOCK_SIZE),
        .CNT_W  (CNT_W)
    ) u_seq (
        .clkIn        (clkIn),
        .resetIn      (resetIn),
        .readyIn      (readyIn),
        .start        (seqStart),
        .step         (seqStep),
        .capture      (seqCapture),
        .clear        (seqClear),
        .base         (seqBase),
        .length       (seqLength),
        .dataIn       (memIn),
        .addr         (seqAddr),
        .count        (seqCount),
        .assembledNext(seqAssembledNext)
    );

    always_comb begin
        case (lsuLen)
            CNT_W'(1): loadWord = {24'b0, seqAssembledNext[LINE_BITS-1 -: 8]};
            CNT_W'(2): loadWord = {16'b0, seqAssembledNext[LINE_BITS-1 -: 16]};
            default:   loadWord = seqAssembledNext[LINE_BITS-1 -: 32];
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            state <= IDLE;
        end else if (readyIn) begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        seqStart    = 1'b0;
        seqStep     = 1'b0;
        seqCapture  = 1'b0;
        seqClear    = 1'b0;
        acceptLsu   = 1'b0;
        acceptFetch = 1'b0;
        finishRead  = 1'b0;
        finishStore = 1'b0;
        case (state)
            IDLE: begin
                // The LSU request is older than the fetch, so it wins.
                if (lsuValid) begin
                    acceptLsu = 1'b1;
                    seqStart  = 1'b1;
                    nextState = lsuWrite ? STORE : LOAD;
                end else if (icacheMiss && !flushIn) begin
                    acceptFetch = 1'b1;
                    seqStart    = 1'b1;
                    nextState   = IFETCH;
                end
            end
            IFETCH, LOAD: begin
                if (state == IFETCH && flushIn) begin
                    seqClear  = 1'b1;
                    nextState = IDLE;
                end else begin
                    // Read data lags the address by a cycle: count k captures byte k-1.
                    seqStep    = 1'b1;
                    seqCapture = (seqCount != '0);
                    if (seqCount == seqLength) begin
                        seqClear   = 1'b1;
                        finishRead = 1'b1;
                        nextState  = DONE;
                    end
                end
            end
            STORE: begin
                if (!ioStall) begin
                    seqStep = 1'b1;
                    if (seqCount == seqLength - 1'b1) begin
                        seqClear    = 1'b1;
                        finishStore = 1'b1;
                        nextState   = DONE;
                    end
                end
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            memOut          <= '0;
            memWriteQ       <= 1'b0;
            storeShift      <= '0;
            lsuLen          <= '0;
            lineAddrQ       <= '0;
            icacheFillValid <= 1'b0;
            icacheFillAddr  <= '0;
            icacheFillData  <= '0;
            lsuDone         <= 1'b0;
            lsuReadData     <= '0;
        end else if (readyIn) begin
            icacheFillValid <= 1'b0;
            lsuDone         <= 1'b0;
            if (acceptLsu) begin
                lsuLen     <= CNT_W'(sizeToBytes(lsuSize));
                memWriteQ  <= lsuWrite;
                memOut     <= lsuWrite ? lsuWriteData[7:0] : 8'h00;
                storeShift <= {8'h00, lsuWriteData[31:8]};
            end
            if (acceptFetch) begin
                lineAddrQ <= icacheMissAddr;
            end
            if (state == STORE && seqStep) begin
                if (finishStore) begin
                    memWriteQ <= 1'b0;
                    memOut    <= 8'h00;
                    lsuDone   <= 1'b1;
                end else begin
                    memOut     <= storeShift[7:0];
                    storeShift <= {8'h00, storeShift[31:8]};
                end
            end
            if (finishRead) begin
                if (state == IFETCH) begin
                    icacheFillValid <= 1'b1;
                    icacheFillAddr  <= lineAddrQ;
                    icacheFillData  <= seqAssembledNext;
                end else begin
                    lsuDone     <= 1'b1;
                    lsuReadData <= loadWord;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed scoreboard bench for mem_controller with a byte-wide RAM model.
module tb_mem_controller;

    logic         clkIn = 1'b0;
    logic         resetIn, readyIn, flushIn;
    logic         icacheMiss;
    logic [31:4]  icacheMissAddr;
    logic         icacheFillValid;
    logic [31:4]  icacheFillAddr;
    logic [127:0] icacheFillData;
    logic         lsuValid, lsuWrite;
    logic [1:0]   lsuSize;
    logic [31:0]  lsuAddr, lsuWriteData;
    logic         lsuDone;
    logic [31:0]  lsuReadData;
    logic [7:0]   memIn, memOut;
    logic [31:0]  memAddr;
    logic         memWrite;
    logic         ioBufferFull;

    int nCompared = 0;
    int nFailed   = 0;
    int cyc       = 0;

    typedef struct {
        logic [1:0]   kind;       // 2'b10 refill, 2'b01 LSU
        logic [127:0] data;
        logic [27:0]  lineAddr;
        int           cycle;
        bit           checkData;
    } sbEntryT;

    sbEntryT sbQ[$];
    sbEntryT e;

    logic [7:0] ram [logic [31:0]];

    mem_controller #(.BLOCK_WIDTH(4)) dut (
        .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .flushIn(flushIn),
        .icacheMiss(icacheMiss), .icacheMissAddr(icacheMissAddr),
        .icacheFillValid(icacheFillValid), .icacheFillAddr(icacheFillAddr),
        .icacheFillData(icacheFillData),
        .lsuValid(lsuValid), .lsuWrite(lsuWrite), .lsuSize(lsuSize),
        .lsuAddr(lsuAddr), .lsuWriteData(lsuWriteData),
        .lsuDone(lsuDone), .lsuReadData(lsuReadData),
        .memIn(memIn), .memOut(memOut), .memAddr(memAddr), .memWrite(memWrite),
        .ioBufferFull(ioBufferFull)
    );

    always #5 clkIn = ~clkIn;

    always @(posedge clkIn) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [31:0] a);
        return 8'(a[7:0] * 8'd7 + a[15:8] + 8'd3);
    endfunction

    function automatic logic [7:0] ramRd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return pat(a);
    endfunction

    function automatic logic [127:0] patLine(input logic [27:0] la);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = pat({la, 4'h0} + 32'(i));
        return l;
    endfunction

    function automatic logic [31:0] patWord(input logic [31:0] a);
        return {pat(a + 3), pat(a + 2), pat(a + 1), pat(a)};
    endfunction

    // RAM output register stalls with the global ready like the rest of the system.
    always @(posedge clkIn) begin
        if (memWrite) ram[memAddr] = memOut;
        if (readyIn) memIn <= ramRd(memAddr);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nFailed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic goCycle(input int c);
        do @(negedge clkIn); while (cyc < c);
    endtask

    task automatic nextEdge();
        @(posedge clkIn);
        #1;
    endtask

    task automatic pushFill(input logic [27:0] la, input logic [127:0] d, input int c);
        sbQ.push_back('{kind: 2'b10, data: d, lineAddr: la, cycle: c, checkData: 1'b1});
    endtask

    task automatic pushLsu(input logic [31:0] d, input bit chk, input int c);
        sbQ.push_back('{kind: 2'b01, data: {96'b0, d}, lineAddr: 28'h0, cycle: c, checkData: chk});
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_memAddr"}, memAddr, 0);
        check({tag, "_memOut"}, memOut, 0);
        check({tag, "_memWrite"}, memWrite, 0);
        check({tag, "_fillValid"}, icacheFillValid, 0);
        check({tag, "_fillAddr"}, icacheFillAddr, 0);
        check({tag, "_fillData"}, icacheFillData, 0);
        check({tag, "_lsuDone"}, lsuDone, 0);
        check({tag, "_lsuReadData"}, lsuReadData, 0);
    endtask

    always @(negedge clkIn) begin
        if (icacheFillValid || lsuDone) begin
            check("pulseExpected", 128'(sbQ.size() != 0), 128'(1));
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                check("pulseKind", {126'b0, icacheFillValid, lsuDone}, {126'b0, e.kind});
                check("pulseCycle", 128'(cyc), 128'(e.cycle));
                if (e.kind == 2'b10) begin
                    check("fillData", icacheFillData, e.data);
                    check("fillAddr", icacheFillAddr, e.lineAddr);
                end else if (e.checkData) begin
                    check("lsuReadData", lsuReadData, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        for (int i = 0; i < 16; i++) ram[32'h100 + 32'(i)] = 8'(i);
        resetIn = 1'b0; readyIn = 1'b1; flushIn = 1'b0;
        icacheMiss = 1'b0; icacheMissAddr = '0;
        lsuValid = 1'b0; lsuWrite = 1'b0; lsuSize = 2'd0; lsuAddr = '0; lsuWriteData = '0;
        ioBufferFull = 1'b0;
        repeat (3) @(posedge clkIn);
        @(negedge clkIn);
        checkAllZero("reset");
        nextEdge();
        resetIn = 1'b1;

        // Refill of line 0x10 from preloaded bytes 0x00..0x0F.
        nextEdge(); a = cyc;
        icacheMiss = 1'b1; icacheMissAddr = 28'h10;
        pushFill(28'h10, 128'h0F0E0D0C0B0A09080706050403020100, a + 18);
        for (int j = 0; j < 16; j++) begin
            goCycle(a + 1 + j);
            check("refillAddr", memAddr, 32'h100 + 32'(j));
        end
        goCycle(a + 1 + 16);
        check("refillNoWrite", memWrite, 0);
        goCycle(a + 18); icacheMiss = 1'b0;
        goCycle(a + 19);
        check("noAcceptInDone", memAddr, 0);

        // Simultaneous miss and word load: load first, refill afterwards.
        nextEdge(); a = cyc;
        icacheMiss = 1'b1; icacheMissAddr = 28'h30;
        lsuValid = 1'b1; lsuWrite = 1'b0; lsuSize = 2'd2; lsuAddr = 32'h200;
        pushLsu(patWord(32'h200), 1'b1, a + 6);
        pushFill(28'h30, patLine(28'h30), a + 25);
        goCycle(a + 1);
        check("lsuWinsAddr", memAddr, 32'h200);
        goCycle(a + 6); lsuValid = 1'b0;
        goCycle(a + 8);
        check("refillAfterLoad", memAddr, 32'h300);
        goCycle(a + 25); icacheMiss = 1'b0;

        // Byte store to the IO window stalled by a full buffer for 3 cycles.
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b1; lsuSize = 2'd0;
        lsuAddr = 32'h30000; lsuWriteData = 32'h000000AB; ioBufferFull = 1'b1;
        pushLsu(32'h0, 1'b0, a + 5);
        for (int j = 1; j <= 3; j++) begin
            goCycle(a + j);
            check("ioStallNoWrite", memWrite, 0);
            check("ioStallAddr", memAddr, 32'h30000);
        end
        nextEdge(); ioBufferFull = 1'b0;
        goCycle(a + 4);
        check("ioWrite", memWrite, 1);
        check("ioWriteData", memOut, 8'hAB);
        goCycle(a + 5); lsuValid = 1'b0;

        // Byte load back from the IO window.
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b0; lsuSize = 2'd0; lsuAddr = 32'h30000;
        pushLsu(32'h000000AB, 1'b1, a + 3);
        goCycle(a + 3); lsuValid = 1'b0;

        // Half store 0xBEEF at 0x40, then read it back.
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b1; lsuSize = 2'd1;
        lsuAddr = 32'h40; lsuWriteData = 32'h1234BEEF;
        pushLsu(32'h0, 1'b0, a + 3);
        goCycle(a + 1);
        check("halfWr0", {memWrite, memAddr, memOut}, {1'b1, 32'h40, 8'hEF});
        goCycle(a + 2);
        check("halfWr1", {memWrite, memAddr, memOut}, {1'b1, 32'h41, 8'hBE});
        goCycle(a + 3); lsuValid = 1'b0;
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b0; lsuSize = 2'd1; lsuAddr = 32'h40;
        pushLsu(32'h0000BEEF, 1'b1, a + 4);
        goCycle(a + 4); lsuValid = 1'b0;

        // Flush at A+5 aborts the refill; a new miss is taken at A+6.
        nextEdge(); a = cyc;
        icacheMiss = 1'b1; icacheMissAddr = 28'h50;
        goCycle(a + 4);
        nextEdge(); flushIn = 1'b1;
        goCycle(a + 5);
        check("flushPreAddr", memAddr, 32'h504);
        nextEdge(); flushIn = 1'b0; icacheMissAddr = 28'h60;
        pushFill(28'h60, patLine(28'h60), a + 24);
        goCycle(a + 6);
        check("flushIdleAddr", memAddr, 0);
        goCycle(a + 7);
        check("flushNewMiss", memAddr, 32'h600);
        goCycle(a + 24); icacheMiss = 1'b0;

        // readyIn low for 4 cycles in the middle of a word load.
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b0; lsuSize = 2'd2; lsuAddr = 32'h80;
        pushLsu(patWord(32'h80), 1'b1, a + 10);
        goCycle(a + 2);
        nextEdge(); readyIn = 1'b0;
        for (int j = 3; j <= 6; j++) begin
            goCycle(a + j);
            check("readyFrozenAddr", memAddr, 32'h82);
            check("readyNoWrite", memWrite, 0);
        end
        nextEdge(); readyIn = 1'b1;
        goCycle(a + 10); lsuValid = 1'b0;

        // readyIn low during a word store forces memWrite low.
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b1; lsuSize = 2'd2;
        lsuAddr = 32'hC0; lsuWriteData = 32'hCAFEF00D;
        pushLsu(32'h0, 1'b0, a + 7);
        goCycle(a + 1);
        check("stWr0", {memWrite, memAddr, memOut}, {1'b1, 32'hC0, 8'h0D});
        nextEdge(); readyIn = 1'b0;
        goCycle(a + 2);
        check("stReadyLow", memWrite, 0);
        goCycle(a + 3);
        check("stReadyLow", memWrite, 0);
        nextEdge(); readyIn = 1'b1;
        goCycle(a + 4);
        check("stWr1", {memWrite, memAddr, memOut}, {1'b1, 32'hC1, 8'hF0});
        goCycle(a + 7); lsuValid = 1'b0;
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b0; lsuSize = 2'd3; lsuAddr = 32'hC0;
        pushLsu(32'hCAFEF00D, 1'b1, a + 6);
        goCycle(a + 6); lsuValid = 1'b0;

        // Reset during the third byte of a word store.
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b1; lsuSize = 2'd2;
        lsuAddr = 32'hD0; lsuWriteData = 32'h11223344;
        goCycle(a + 2);
        nextEdge(); resetIn = 1'b0; lsuValid = 1'b0;
        goCycle(a + 3);
        check("rstThirdByte", {memWrite, memAddr, memOut}, {1'b1, 32'hD2, 8'h22});
        nextEdge(); resetIn = 1'b1;
        goCycle(a + 4);
        checkAllZero("midReset");
        goCycle(a + 5);
        check("postResetNoWrite", memWrite, 0);
        nextEdge(); a = cyc;
        lsuValid = 1'b1; lsuWrite = 1'b0; lsuSize = 2'd2; lsuAddr = 32'hD0;
        pushLsu({pat(32'hD3), 8'h22, 8'h33, 8'h44}, 1'b1, a + 6);
        goCycle(a + 1);
        check("postResetLoadAddr", memAddr, 32'hD0);
        goCycle(a + 6); lsuValid = 1'b0;

        goCycle(a + 10);
        check("scoreboardDrained", 128'(sbQ.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
